// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the mips core's instruction memory. It accepts
// a byte stream over a valid/ready handshake. The stream layout is:
//   - a 16-bit little-endian word count,
//   - len little-endian 32-bit words,
//   - one XOR checksum byte covering the data bytes.
// Each assembled word goes to the instruction-memory write port. The core is
// held in reset until a complete image with a matching checksum has landed.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous reset, active low
//   start      : one-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   in_valid   : byte offered on in_data
//   in_data    : stream byte
//   in_ready   : byte can be accepted (LEN0/LEN1/DATA/CSUM)
//   mem_we     : one-cycle word write strobe
//   mem_addr   : word-aligned byte address of the write
//   mem_wdata  : word to write, [7:0] = first byte received
//   core_hold  : 1 keeps the core in reset
//   busy       : load in progress
//   done       : last load completed with a good checksum
//   err        : last load failed (bad length or checksum)
// ----------------------------------------------------------------------------
module imem_loader #(
   parameter int unsigned ADDR_W    = 7,
   parameter int unsigned MAX_WORDS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Wide enough to hold MAX_WORDS itself, not just MAX_WORDS-1.
   localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] word_cnt;
   logic [1:0]       byte_idx;
   logic [15:0]      len;
   logic [7:0]       csum;
   logic [23:0]      byte_buf;   // bytes 0..2 of the word being assembled

   logic              hs;
   logic [15:0]       len_full;
   logic              len_bad;
   logic              last_word;
   logic [ADDR_W-1:0] word_addr;
   logic [7:0]        csum_next;

   always_comb begin
      hs        = in_valid & in_ready;
      len_full  = {in_data, len[7:0]};
      len_bad   = (len_full == 16'd0) || (len_full > 16'(MAX_WORDS));
      last_word = ((16'(word_cnt) + 16'd1) == len);
      word_addr = ADDR_W'({word_cnt, 2'b00});
      csum_next = csum ^ in_data;
   end

   // in_ready is registered alongside the state. It is therefore set on
   // every transition into LEN0..CSUM and cleared on every transition out.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         word_cnt  <= '0;
         byte_idx  <= '0;
         len       <= '0;
         csum      <= '0;
         byte_buf  <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         core_hold <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;

         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state     <= LEN0;
                  word_cnt  <= '0;
                  byte_idx  <= '0;
                  csum      <= '0;
                  in_ready  <= 1'b1;
                  core_hold <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  err       <= 1'b0;
               end
            end

            LEN0: begin
               if (hs) begin
                  len[7:0] <= in_data;
                  state    <= LEN1;
               end
            end

            LEN1: begin
               if (hs) begin
                  len[15:8] <= in_data;
                  if (len_bad) begin
                     state    <= ERR;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end

            DATA: begin
               if (hs) begin
                  csum     <= csum_next;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: byte_buf[7:0]   <= in_data;
                     2'd1: byte_buf[15:8]  <= in_data;
                     2'd2: byte_buf[23:16] <= in_data;
                     default: begin
                        // The fourth byte goes straight into the word. It
                        // never passes through byte_buf.
                        mem_wdata <= {in_data, byte_buf};
                        mem_addr  <= word_addr;
                        mem_we    <= 1'b1;
                        word_cnt  <= word_cnt + CNT_W'(1);
                        if (last_word) begin
                           state <= CSUM;
                        end
                     end
                  endcase
               end
            end

            CSUM: begin
               if (hs) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (in_data == csum) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     core_hold <= 1'b0;
                  end else begin
                     state     <= ERR;
                     err       <= 1'b1;
                     core_hold <= 1'b1;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
